// File: rtl/hog_block_scorer.sv
// Linear-SVM partial scorer for HOG blocks: 36-term signed dot product of a block's features
// with weights streamed from a synchronous ROM, with a one-deep pending slot for a block that arrives while busy.
module hog_block_scorer #(
    parameter int BID_W = 13,
    parameter int FEA_I = 4,
    parameter int FEA_F = 28,
    parameter int W_W   = 16,
    parameter int W_F   = 12,
    localparam int FEA_W = FEA_I + FEA_F,
    localparam int ACC_W = FEA_W + W_W + 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [BID_W-1:0]        i_bid,
    input  logic [9*FEA_W-1:0]      fea_a,
    input  logic [9*FEA_W-1:0]      fea_b,
    input  logic [9*FEA_W-1:0]      fea_c,
    input  logic [9*FEA_W-1:0]      fea_d,
    input  logic                    i_valid,
    output logic                    wt_rd_en,
    output logic [BID_W+5:0]        wt_addr,
    input  logic signed [W_W-1:0]   wt_data,
    output logic [ACC_W-1:0]        score,
    output logic [BID_W-1:0]        score_bid,
    output logic                    score_valid,
    output logic                    busy,
    output logic                    overflow,
    output logic [1:0]              dbg_state_o
);

    localparam int          NFEA   = 36;
    localparam int          FV_W   = NFEA * FEA_W;
    localparam int          PROD_W = FEA_W + W_W + 1;
    localparam logic [5:0]  LAST_K = 6'd35;

    // The score carries FEA_F+W_F fractional bits; it must leave room for integer bits.
    if (FEA_F + W_F >= ACC_W) begin : g_fmt_check
        $error("hog_block_scorer: score fractional bits exceed accumulator width");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         k_q, k_d;
    logic               dcnt_q, dcnt_d;
    logic [BID_W-1:0]   work_bid_q, work_bid_d;
    logic [FV_W-1:0]    work_fea_q, work_fea_d;
    logic [BID_W-1:0]   pend_bid_q, pend_bid_d;
    logic [FV_W-1:0]    pend_fea_q, pend_fea_d;
    logic               pend_v_q, pend_v_d;
    logic               mac_v_q, mac_v_d;
    logic [5:0]         mac_k_q, mac_k_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   score_q, score_d;
    logic [BID_W-1:0]   score_bid_q, score_bid_d;
    logic               score_valid_q, score_valid_d;
    logic               overflow_q, overflow_d;

    logic [FV_W-1:0]          in_fea;
    logic [FEA_W-1:0]         fea_sel;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         prod_ext;
    logic                     finish;
    logic                     start;

    assign in_fea = {fea_d, fea_c, fea_b, fea_a};

    // MAC stage lags the address by one cycle: weight k arrives while mac_k_q == k.
    always_comb begin
        fea_sel = '0;
        for (int i = 0; i < NFEA; i++) begin
            if (mac_k_q == 6'(i)) begin
                fea_sel = work_fea_q[i*FEA_W +: FEA_W];
            end
        end
    end

    assign prod     = $signed({1'b0, fea_sel}) * wt_data;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign finish   = (state_q == S_DRAIN) && dcnt_q;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        dcnt_d        = dcnt_q;
        work_bid_d    = work_bid_q;
        work_fea_d    = work_fea_q;
        pend_bid_d    = pend_bid_q;
        pend_fea_d    = pend_fea_q;
        pend_v_d      = pend_v_q;
        mac_v_d       = (state_q == S_RUN);
        mac_k_d       = k_q;
        acc_d         = mac_v_q ? acc_q + prod_ext : acc_q;
        score_d       = score_q;
        score_bid_d   = score_bid_q;
        score_valid_d = 1'b0;
        overflow_d    = overflow_q;
        start         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    work_bid_d = i_bid;
                    work_fea_d = in_fea;
                    start      = 1'b1;
                end
            end
            S_RUN: begin
                k_d = k_q + 6'd1;
                if (k_q == LAST_K) begin
                    state_d = S_DRAIN;
                    dcnt_d  = 1'b0;
                end
            end
            S_DRAIN: dcnt_d = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Result edge: the pending slot is freed and refilled in the same cycle, so no block is lost here.
        if (finish) begin
            score_d       = acc_q;
            score_bid_d   = work_bid_q;
            score_valid_d = 1'b1;
            if (pend_v_q) begin
                work_bid_d = pend_bid_q;
                work_fea_d = pend_fea_q;
                start      = 1'b1;
                pend_v_d   = i_valid;
                if (i_valid) begin
                    pend_bid_d = i_bid;
                    pend_fea_d = in_fea;
                end
            end else if (i_valid) begin
                work_bid_d = i_bid;
                work_fea_d = in_fea;
                start      = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end else if ((state_q != S_IDLE) && i_valid) begin
            if (!pend_v_q) begin
                pend_bid_d = i_bid;
                pend_fea_d = in_fea;
                pend_v_d   = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (start) begin
            state_d = S_RUN;
            k_d     = 6'd0;
            dcnt_d  = 1'b0;
            acc_d   = '0;
        end

        // Flush keeps the last published score visible.
        if (clear) begin
            state_d       = S_IDLE;
            k_d           = 6'd0;
            dcnt_d        = 1'b0;
            work_bid_d    = work_bid_q;
            work_fea_d    = work_fea_q;
            pend_bid_d    = pend_bid_q;
            pend_fea_d    = pend_fea_q;
            pend_v_d      = 1'b0;
            mac_v_d       = 1'b0;
            acc_d         = '0;
            score_d       = score_q;
            score_bid_d   = score_bid_q;
            score_valid_d = 1'b0;
            overflow_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            dcnt_q        <= 1'b0;
            work_bid_q    <= '0;
            work_fea_q    <= '0;
            pend_bid_q    <= '0;
            pend_fea_q    <= '0;
            pend_v_q      <= 1'b0;
            mac_v_q       <= 1'b0;
            mac_k_q       <= '0;
            acc_q         <= '0;
            score_q       <= '0;
            score_bid_q   <= '0;
            score_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            dcnt_q        <= dcnt_d;
            work_bid_q    <= work_bid_d;
            work_fea_q    <= work_fea_d;
            pend_bid_q    <= pend_bid_d;
            pend_fea_q    <= pend_fea_d;
            pend_v_q      <= pend_v_d;
            mac_v_q       <= mac_v_d;
            mac_k_q       <= mac_k_d;
            acc_q         <= acc_d;
            score_q       <= score_d;
            score_bid_q   <= score_bid_d;
            score_valid_q <= score_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    assign wt_rd_en    = (state_q == S_RUN);
    assign wt_addr     = wt_rd_en ? {work_bid_q, k_q} : '0;
    assign score       = score_q;
    assign score_bid   = score_bid_q;
    assign score_valid = score_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hog_block_scorer.sv
// Bench for hog_block_scorer: ROM model, block-level reference model, per-cycle compare and directed/random stimulus.
module tb_hog_block_scorer;

    localparam int BID_W = 13;
    localparam int FEA_W = 32;
    localparam int ACC_W = 55;
    localparam int FV_W  = 36 * FEA_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  clear = 1'b0;
    logic                  i_valid = 1'b0;
    logic [BID_W-1:0]      i_bid = '0;
    logic [9*FEA_W-1:0]    fea_a = '0, fea_b = '0, fea_c = '0, fea_d = '0;
    logic                  wt_rd_en;
    logic [BID_W+5:0]      wt_addr;
    logic signed [15:0]    wt_data;
    logic [ACC_W-1:0]      score;
    logic [BID_W-1:0]      score_bid;
    logic                  score_valid, busy, overflow;
    logic [1:0]            dbg_state;

    hog_block_scorer dut (
        .clk(clk), .rst(rst), .clear(clear), .i_bid(i_bid),
        .fea_a(fea_a), .fea_b(fea_b), .fea_c(fea_c), .fea_d(fea_d),
        .i_valid(i_valid), .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_data(wt_data),
        .score(score), .score_bid(score_bid), .score_valid(score_valid),
        .busy(busy), .overflow(overflow), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- weight ROM ----------------
    logic signed [15:0] wt_tab [64];
    int                 wt_bid_mul = 0;

    function automatic logic signed [15:0] rom_w(input logic [BID_W+5:0] a);
        int v;
        v = int'(wt_tab[a[5:0]]) + int'(a[BID_W+5:6]) * wt_bid_mul;
        return 16'(v);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) wt_data <= '0;
        else if (wt_rd_en) wt_data <= rom_w(wt_addr);
    end

    // ---------------- reference model ----------------
    function automatic longint dot(input logic [BID_W-1:0] b, input logic [FV_W-1:0] fv);
        longint s = 0;
        for (int k = 0; k < 36; k++)
            s += longint'(fv[k*FEA_W +: FEA_W]) * longint'(rom_w({b, 6'(k)}));
        return s;
    endfunction

    int                 cyc = 0;
    bit                 m_active, m_pv, m_ovf, m_sv;
    int                 m_start;
    logic [BID_W-1:0]   m_bid, m_pbid, m_sbid;
    logic [FV_W-1:0]    m_fv, m_pfv;
    logic [ACC_W-1:0]   m_score;
    logic [BID_W+ACC_W-1:0] exp_q[$];

    // A block occupies the scorer for 38 edges after its capture; its result appears at the 38th.
    always @(posedge clk) begin : model
        logic [FV_W-1:0] in_fv;
        bit fin;
        cyc++;
        in_fv = {fea_d, fea_c, fea_b, fea_a};
        if (rst) begin
            m_active = 0; m_pv = 0; m_ovf = 0; m_sv = 0;
            m_score = '0; m_sbid = '0;
        end else begin
            fin  = m_active && (cyc - m_start == 38);
            m_sv = 0;
            if (clear) begin
                m_active = 0; m_pv = 0; m_ovf = 0;
            end else if (fin) begin
                m_sv = 1;
                m_score = ACC_W'(dot(m_bid, m_fv));
                m_sbid = m_bid;
                exp_q.push_back({m_sbid, m_score});
                if (m_pv) begin
                    m_bid = m_pbid; m_fv = m_pfv; m_start = cyc; m_pv = 0;
                    if (i_valid) begin m_pbid = i_bid; m_pfv = in_fv; m_pv = 1; end
                end else if (i_valid) begin
                    m_bid = i_bid; m_fv = in_fv; m_start = cyc;
                end else begin
                    m_active = 0;
                end
            end else if (!m_active) begin
                if (i_valid) begin m_bid = i_bid; m_fv = in_fv; m_start = cyc; m_active = 1; end
            end else if (i_valid) begin
                if (!m_pv) begin m_pbid = i_bid; m_pfv = in_fv; m_pv = 1; end
                else m_ovf = 1;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [ACC_W-1:0] got_s[$];
    logic [BID_W-1:0] got_b[$];
    int               got_t[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin : cmp
        int age;
        logic e_rd;
        logic [BID_W+5:0] e_addr;
        logic [BID_W+ACC_W-1:0] e;
        #2;
        age    = cyc - m_start;
        e_rd   = m_active && (age < 36);
        e_addr = e_rd ? {m_bid, 6'(age)} : '0;
        chk("busy", 64'(busy), 64'(m_active));
        chk("wt_rd_en", 64'(wt_rd_en), 64'(e_rd));
        chk("wt_addr", 64'(wt_addr), 64'(e_addr));
        chk("score_valid", 64'(score_valid), 64'(m_sv));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("score", 64'(score), 64'(m_score));
        chk("score_bid", 64'(score_bid), 64'(m_sbid));
        if (score_valid) begin
            got_s.push_back(score); got_b.push_back(score_bid); got_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_score", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_score", 64'(score), 64'(e[ACC_W-1:0]));
                chk("sb_bid", 64'(score_bid), 64'(e[BID_W+ACC_W-1:ACC_W]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the block is captured at the following posedge.
    task automatic send(input logic [BID_W-1:0] b, input logic [FV_W-1:0] fv, output int cap);
        i_valid = 1'b1;
        i_bid   = b;
        {fea_d, fea_c, fea_b, fea_a} = fv;
        cap = cyc + 1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic clr_log();
        got_s.delete(); got_b.delete(); got_t.delete();
    endtask

    function automatic logic [FV_W-1:0] fv_const(input logic [31:0] v);
        logic [FV_W-1:0] fv;
        for (int k = 0; k < 36; k++) fv[k*FEA_W +: FEA_W] = v;
        return fv;
    endfunction

    function automatic logic [FV_W-1:0] fv_ramp();
        logic [FV_W-1:0] fv;
        for (int k = 0; k < 36; k++) fv[k*FEA_W +: FEA_W] = 32'(k) << 28;
        return fv;
    endfunction

    function automatic logic [FV_W-1:0] fv_rand();
        logic [FV_W-1:0] fv;
        for (int k = 0; k < 36; k++) fv[k*FEA_W +: FEA_W] = $urandom;
        return fv;
    endfunction

    // ---------------- stimulus ----------------
    logic [FV_W-1:0] fv1, fv2;
    int capa, capb, capc, gap;
    logic [63:0] one40;

    initial begin
        one40 = 64'd1 << 40;
        for (int k = 0; k < 64; k++) wt_tab[k] = 16'sd4096;
        fv1 = fv_const(32'h1000_0000);
        fv2 = fv_ramp();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_rd_en", 64'(wt_rd_en), 0);
        chk("rst_addr", 64'(wt_addr), 0);
        chk("rst_score", 64'(score), 0);
        chk("rst_valid", 64'(score_valid), 0);
        chk("rst_ovf", 64'(overflow), 0);
        rst = 1'b0;
        idle(2);

        // single block, unity features and weights
        chk("pin_dot_unity", 64'(dot(13'd5, fv1)), 36 * one40);
        clr_log();
        send(13'd5, fv1, capa);
        for (int k = 0; k < 36; k++) begin
            chk("t1_addr_sweep", 64'(wt_addr), 64'(320 + k));
            @(negedge clk);
        end
        idle(10);
        chk("t1_count", 64'(got_s.size()), 1);
        if (got_s.size() >= 1) begin
            chk("t1_score", 64'(got_s[0]), 36 * one40);
            chk("t1_bid", 64'(got_b[0]), 5);
            chk("t1_latency", 64'(got_t[0]), 64'(capa + 38));
        end

        // signed weights: -1.0 on even k, +1.0 on odd k
        for (int k = 0; k < 36; k++) wt_tab[k] = (k % 2 == 0) ? -16'sd4096 : 16'sd4096;
        chk("pin_dot_signed", 64'(dot(13'd6, fv2)), 18 * one40);
        clr_log();
        send(13'd6, fv2, capa);
        idle(45);
        chk("t2_count", 64'(got_s.size()), 1);
        if (got_s.size() >= 1) chk("t2_score", 64'(got_s[0]), 18 * one40);

        // two blocks 10 apart: second queued
        for (int k = 0; k < 64; k++) wt_tab[k] = 16'sd4096;
        clr_log();
        send(13'd1, fv1, capa);
        idle(9);
        send(13'd2, fv1, capb);
        idle(80);
        chk("t3_count", 64'(got_s.size()), 2);
        if (got_s.size() >= 2) begin
            chk("t3_t0", 64'(got_t[0]), 64'(capa + 38));
            chk("t3_t1", 64'(got_t[1]), 64'(capa + 76));
            chk("t3_bid1", 64'(got_b[1]), 2);
        end
        chk("t3_ovf", 64'(overflow), 0);

        // three blocks 5 apart: third dropped
        clr_log();
        send(13'd1, fv1, capa);
        idle(4);
        send(13'd2, fv1, capb);
        idle(4);
        send(13'd3, fv1, capc);
        idle(85);
        chk("t4_count", 64'(got_s.size()), 2);
        if (got_s.size() >= 2) chk("t4_bid1", 64'(got_b[1]), 2);
        chk("t4_ovf", 64'(overflow), 1);
        pulse_clear();
        chk("t4_ovf_cleared", 64'(overflow), 0);

        // new block exactly at the result edge while pending is full
        clr_log();
        send(13'd10, fv1, capa);
        idle(4);
        send(13'd11, fv1, capb);
        while (cyc < capa + 37) @(negedge clk);
        send(13'd12, fv1, capc);
        chk("t5_cap_at_e38", 64'(capc), 64'(capa + 38));
        idle(120);
        chk("t5_count", 64'(got_s.size()), 3);
        if (got_s.size() >= 3) begin
            chk("t5_t0", 64'(got_t[0]), 64'(capa + 38));
            chk("t5_t1", 64'(got_t[1]), 64'(capa + 76));
            chk("t5_t2", 64'(got_t[2]), 64'(capa + 114));
            chk("t5_bid2", 64'(got_b[2]), 12);
        end
        chk("t5_ovf", 64'(overflow), 0);

        // reset mid-run, then a fresh block
        clr_log();
        send(13'd7, fv1, capa);
        idle(19);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy", 64'(busy), 0);
        chk("t6_rst_score", 64'(score), 0);
        chk("t6_rst_rd_en", 64'(wt_rd_en), 0);
        idle(2);
        rst = 1'b0;
        idle(50);
        chk("t6_no_stale", 64'(got_s.size()), 0);
        send(13'd9, fv1, capa);
        idle(45);
        chk("t6_count", 64'(got_s.size()), 1);
        if (got_s.size() >= 1) begin
            chk("t6_score", 64'(got_s[0]), 36 * one40);
            chk("t6_latency", 64'(got_t[0]), 64'(capa + 38));
        end

        // clear mid-run with overflow set: score held, overflow cleared
        clr_log();
        send(13'd3, fv1, capa);
        idle(4);
        send(13'd4, fv1, capb);
        idle(4);
        send(13'd5, fv1, capc);
        chk("t7_ovf_set", 64'(overflow), 1);
        while (cyc < capa + 20) @(negedge clk);
        pulse_clear();
        chk("t7_score_held", 64'(score), 36 * one40);
        chk("t7_bid_held", 64'(score_bid), 9);
        chk("t7_ovf", 64'(overflow), 0);
        chk("t7_busy", 64'(busy), 0);
        idle(60);
        chk("t7_no_stale", 64'(got_s.size()), 0);
        send(13'd8, fv1, capa);
        idle(45);
        chk("t7_count", 64'(got_s.size()), 1);
        if (got_s.size() >= 1) chk("t7_bid", 64'(got_b[0]), 8);

        // randomized traffic against the model
        wt_bid_mul = 1;
        for (int k = 0; k < 64; k++) wt_tab[k] = 16'($urandom);
        for (int n = 0; n < 250; n++) begin
            clear = ($urandom_range(0, 24) == 0);
            send(13'($urandom_range(0, 8191)), fv_rand(), capa);
            clear = 1'b0;
            gap = $urandom_range(0, 45);
            for (int g = 0; g < gap; g++) begin
                clear = ($urandom_range(0, 59) == 0);
                @(negedge clk);
                clear = 1'b0;
            end
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        idle(120);
        chk("exp_q_drained", 64'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
